// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter and sequencer for the shared 4-to-1, 1-bit mux datapath.
// Four requesters compete for one mux output. One requester is granted at a
// time. The block drives the mux select pair {s1,s0} (sel[1] -> s1,
// sel[0] -> s0) and registers the selected bit as a valid-qualified output.
//
// Optional feature macro: MUX_ARB_TIMEOUT_EN
//   defined   : a grant ends after at most HOLD_MAX cycles, even if the owner
//               keeps requesting. The owner then rotates to lowest priority.
//   undefined : a grant is held until the owner drops its request. The hold
//               counter is not built and HOLD_MAX only gets its range check.
//
// Parameters
//   HOLD_MAX    maximum grant length in cycles with timeout enabled (2..15)
//
// Ports
//   clk         in   1  system clock, rising edge
//   resetn      in   1  asynchronous active-low reset
//   req         in   4  level-held request lines, one per requester
//   din         in   4  mux data bits: din[0]=u, din[1]=v, din[2]=w, din[3]=x
//   gnt         out  4  one-hot grant, all zero when idle
//   sel         out  2  mux select {s1,s0}; index n routes din[n]
//   dout        out  1  registered mux output, din[sel] one cycle late
//   dout_valid  out  1  dout carries the granted requester's data
//   busy        out  1  high while a grant is active
// -----------------------------------------------------------------------------
module mux4_rr_arbiter #(
   parameter int unsigned HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [3:0] req,
   input  logic [3:0] din,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       dout,
   output logic       dout_valid,
   output logic       busy
);

   // Reject an out-of-range grant length when the design is elaborated.
   if (HOLD_MAX < 2 || HOLD_MAX > 15) begin : g_bad_hold_max
      $error("mux4_rr_arbiter: HOLD_MAX must lie in 2..15");
   end

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     state;
   logic [1:0] ptr;       // highest-priority requester for the next search
   logic [1:0] winner;    // first set request in search order from ptr
   logic [1:0] idx;
   logic       release_now;

`ifdef MUX_ARB_TIMEOUT_EN
   localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);
   logic [3:0] hold_cnt;
`endif

   // Round-robin search: ptr, ptr+1, ptr+2, ptr+3 (modulo 4). Walk the order
   // from lowest to highest priority so that the highest-priority hit is
   // assigned last and wins. The result is only used when req is non-zero.
   always_comb begin
      // NOTE: every variable driven here gets a default first. A path that
      // leaves one unassigned would infer a latch.
      winner = ptr;
      idx    = ptr;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (req[idx]) begin
            winner = idx;
         end
      end
   end

   // While in GRANT, sel names the owner. The grant ends when the owner's
   // request is sampled low or the hold limit is reached. If both happen on
   // the same edge, there is still only one release.
   always_comb begin
      release_now = !req[sel];
`ifdef MUX_ARB_TIMEOUT_EN
      if (hold_cnt == HOLD_LAST) begin
         release_now = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         ptr        <= 2'd0;
         gnt        <= 4'b0000;
         sel        <= 2'd0;
         busy       <= 1'b0;
         dout       <= 1'b0;
         dout_valid <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
         hold_cnt   <= 4'd0;
`endif
      end else begin
         // NOTE: all state here uses non-blocking assignments. dout therefore
         // samples the sel value from before this edge, and dout_valid samples
         // the state from before this edge.
         dout       <= din[sel];
         dout_valid <= (state == GRANT);

         case (state)
            IDLE: begin
               // With no requests, sel keeps its last value.
               if (req != 4'b0000) begin
                  state    <= GRANT;
                  gnt      <= 4'b0001 << winner;
                  sel      <= winner;
                  busy     <= 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
                  hold_cnt <= 4'd0;
`endif
               end
            end

            GRANT: begin
`ifdef MUX_ARB_TIMEOUT_EN
               if (hold_cnt != 4'd15) begin
                  hold_cnt <= hold_cnt + 4'd1;
               end
`endif
               // Requests from non-owners are not latched. They are looked at
               // again in the IDLE cycle that always follows a release, so
               // the mux select settles before the next owner is granted.
               if (release_now) begin
                  state <= IDLE;
                  gnt   <= 4'b0000;
                  busy  <= 1'b0;
                  ptr   <= sel + 2'd1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

   localparam int unsigned HOLD_MAX = 4;

   logic       clk    = 1'b0;
   logic       resetn = 1'b1;
   logic [3:0] req    = 4'b0000;
   logic [3:0] din    = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       dout;
   logic       dout_valid;
   logic       busy;

   always #5 clk = ~clk;

   mux4_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .req        (req),
      .din        (din),
      .gnt        (gnt),
      .sel        (sel),
      .dout       (dout),
      .dout_valid (dout_valid),
      .busy       (busy)
   );

   int unsigned total  = 0;
   int unsigned passed = 0;
   int unsigned failed = 0;

   // Expected outputs as they currently stand, set by the directed steps.
   logic [3:0] exp_gnt = 4'b0000;
   logic [1:0] exp_sel = 2'd0;

   // Scoreboard of {dout_valid, dout} expected after the next edge.
   logic [1:0] sb_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge. Before the edge, push the expected dout/dout_valid that
   // the current outputs imply. After the edge, adopt the expected grant g and
   // select s and compare everything.
   task automatic tick(input logic [3:0] g, input logic [1:0] s);
      logic [1:0] e;
      sb_q.push_back({(exp_gnt != 4'b0000), din[exp_sel]});
      @(posedge clk);
      #1;
      exp_gnt = g;
      exp_sel = s;
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("sel", 32'(sel), 32'(exp_sel));
      check("busy", 32'(busy), 32'(exp_gnt != 4'b0000));
      e = sb_q.pop_front();
      check("dout_valid", 32'(dout_valid), 32'(e[1]));
      check("dout", 32'(dout), 32'(e[0]));
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_gnt"}, 32'(gnt), 32'h0);
      check({tag, "_sel"}, 32'(sel), 32'h0);
      check({tag, "_dout"}, 32'(dout), 32'h0);
      check({tag, "_dout_valid"}, 32'(dout_valid), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
   endtask

   task automatic do_reset(input string tag);
      #1;
      resetn = 1'b0;
      #1;
      check_reset_state({tag, "_async"});
      @(posedge clk);
      #1;
      check_reset_state({tag, "_held"});
      resetn  = 1'b1;
      exp_gnt = 4'b0000;
      exp_sel = 2'd0;
      sb_q.delete();
   endtask

   initial begin
      // Reset with all requesters active; the first grant goes to ptr=0.
      req = 4'b1111;
      din = 4'b0000;
      do_reset("reset");
      tick(4'b0001, 2'd0);
      req = 4'b0000;
      tick(4'b0000, 2'd0);                 // release, ptr -> 1

      // Single requester 2 held for 5 grant cycles, then dropped.
      req = 4'b0100;
      din = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         tick(4'b0100, 2'd2);
      end
      req = 4'b0000;
      tick(4'b0000, 2'd2);                 // gnt falls, last valid data out
      tick(4'b0000, 2'd2);                 // idle: sel holds, dout_valid low

      // Data path: owner 3 granted, din[3] toggles, other bits random.
      req = 4'b1000;
      tick(4'b1000, 2'd3);
      for (int i = 0; i < 6; i++) begin
         din = {~din[3], 3'($urandom)};
         tick(4'b1000, 2'd3);
      end

      // Asynchronous reset in the middle of the grant.
      #3;
      resetn = 1'b0;
      #1;
      check_reset_state("midgrant");
      sb_q.delete();
      exp_gnt = 4'b0000;
      exp_sel = 2'd0;
      @(posedge clk);
      #1;
      req    = 4'b1111;
      din    = 4'b1010;
      resetn = 1'b1;

      // Rotation: each owner holds for 3 cycles, drops, then re-raises.
      // The search restarts from ptr=0 after the reset.
      for (int o = 0; o < 4; o++) begin
         req = 4'b1111;
         for (int c = 0; c < 3; c++) begin
            tick(4'(4'b0001 << o), 2'(o));
         end
         req[o] = 1'b0;
         tick(4'b0000, 2'(o));             // one IDLE cycle between grants
      end
      req = 4'b1111;
      tick(4'b0001, 2'd0);
      req = 4'b0000;
      tick(4'b0000, 2'd0);

      // Two permanent requesters: timeout rotation or an indefinite hold.
      din = 4'b0001;
      do_reset("reset2");
      req = 4'b0011;
`ifdef MUX_ARB_TIMEOUT_EN
      for (int c = 0; c < int'(HOLD_MAX); c++) begin
         tick(4'b0001, 2'd0);
      end
      tick(4'b0000, 2'd0);
      for (int c = 0; c < int'(HOLD_MAX); c++) begin
         tick(4'b0010, 2'd1);
      end
      tick(4'b0000, 2'd1);
      tick(4'b0001, 2'd0);
`else
      for (int c = 0; c < 12; c++) begin
         tick(4'b0001, 2'd0);
      end
`endif
      req = 4'b0000;
      tick(4'b0000, 2'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

- Round-robin arbiter and sequencer for the shared 4-to-1, 1-bit mux datapath.
- Four requesters compete for the single mux output. The block grants one requester at a time, drives the mux select pair {s1,s0}, and registers the selected bit as a valid-qualified output.
- Sits between the requesting logic and the mux4to1 instance; sel[1] drives s1 and sel[0] drives s0.

## Interface

- HOLD_MAX, 8: maximum grant length in cycles when the timeout feature is compiled in; legal range 2..15.
- clk  input  1  system clock, rising-edge.
- resetn  input  1  asynchronous, active-low reset.
- req  input  4  request lines, one per requester; req[i] level-held while requester i wants the output.
- din  input  4  data bits; din[0]=u, din[1]=v, din[2]=w, din[3]=x.
- gnt  output  4  one-hot grant; all zero when idle.
- sel  output  2  mux select; index = {s1,s0}; 0→din[0] … 3→din[3].
- dout  output  1  registered mux output.
- dout_valid  output  1  dout carries granted requester's data.
- busy  output  1  high while in GRANT.

## Operation

- States: IDLE, GRANT.
- Round-robin pointer ptr[1:0] names the highest-priority requester. Search order is ptr, ptr+1, ptr+2, ptr+3, modulo 4.
- IDLE:
  - If req≠0, pick the first set req in search order as owner, then go to GRANT.
  - On entering GRANT: gnt=one-hot(owner), sel=owner, busy=1, hold counter cleared to 0.
  - If req=0, stay in IDLE; sel holds its last value.
- GRANT: gnt and sel stay constant. Release occurs when:
  - req[owner] is sampled 0, or
  - with timeout compiled in, the hold counter equals HOLD_MAX-1.
- On release:
  - State goes to IDLE; gnt=0; busy=0; ptr=owner+1 (wraps 3→0); sel unchanged.
  - At least one IDLE cycle always separates two grants. This guarantees the mux select settles before the next owner.
- Requests from non-owners during GRANT are ignored. They are not latched and are re-evaluated in IDLE.
- dout is updated every edge with din[sel] (the value of sel before the edge). dout_valid is updated every edge with (state==GRANT) (the state before the edge).
- Hold counter: 4 bits. Increments each cycle in GRANT, saturates at 15, cleared on entry to GRANT.

## Timing

- Reset (resetn=0, asynchronous): state=IDLE, gnt=0, sel=0, dout=0, dout_valid=0, busy=0, ptr=0, counter=0.
- Reset mid-grant drops gnt and dout_valid immediately, without waiting for clk.
- Request to grant latency: req sampled high at edge E0 in IDLE gives gnt/sel/busy valid after E0.
- Grant to data latency: first valid dout appears after E1 = E0+1. dout_valid is high for exactly as many cycles as gnt was high, delayed by one cycle.
- Requester drop: req[owner] sampled 0 at edge Er makes gnt fall after Er. dout_valid falls after Er+1. The data captured at Er is still valid.
- Simultaneous requests in IDLE: only the search-order winner is granted.
- A requester re-requests immediately after release: it is granted again only if no other requester is set. Because ptr moved past it, it is lowest priority.
- Owner drops req on the same edge the timeout hits: a single release occurs, identical to either cause alone.

## Configuration

- MUX_ARB_TIMEOUT_EN:
  - Defined: grant ends after at most HOLD_MAX cycles even if req[owner] stays high. The owner then rotates to lowest priority.
  - Undefined: grant is held until req[owner] drops. The counter is not compiled in and HOLD_MAX is ignored.

## Test plan

- Reset: hold resetn=0 with req=4'b1111. Required: gnt=0, sel=0, dout=0, dout_valid=0, busy=0. Release reset; one edge later gnt=4'b0001, sel=0.
- Single requester: req=4'b0100, din=4'b0100, held 5 cycles, then dropped. Required: gnt=4'b0100 and sel=2 for 5 cycles; dout=1 with dout_valid=1 for 5 cycles, one cycle delayed; then gnt=0.
- Rotation: req=4'b1111, each owner drops its req after 3 grant cycles then re-raises it. Required grant order 0,1,2,3,0, with one IDLE cycle between each grant.
- Data path: owner 3 granted, din[3] toggled every cycle. Required: dout tracks din[3] one cycle late; changes on din[0..2] have no effect.
- Timeout, with MUX_ARB_TIMEOUT_EN and HOLD_MAX=4: req=4'b0011 held permanently. Required: gnt=0001 for 4 cycles, IDLE, then 0010 for 4 cycles, IDLE, then 0001. Without the macro, gnt=0001 is held indefinitely.
- Mid-grant reset: assert resetn=0 asynchronously during GRANT. Required: gnt and dout_valid go to 0 before the next clk edge; after release, arbitration restarts from ptr=0.
